// File: rtl/decode_issue_pkg.sv
// Shared types and constants for the decode/issue sequencer.
// Optional feature macro used by the top: DECODE_ISSUE_PERF_EN (issue/trap counters).
package decode_issue_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    localparam int INST_W = 32;
    localparam int PERF_W = 16;

    // Encodings the lookup decoder rejects; also handy as bench stimulus.
    localparam logic [INST_W-1:0] ILL_A = 32'h0000_257b;
    localparam logic [INST_W-1:0] ILL_B = 32'h0000_277b;

    function automatic logic is_illegal(input logic [INST_W-1:0] word);
        return (word == ILL_A) || (word == ILL_B);
    endfunction

endpackage

// File: rtl/inst_lookup_decoder.sv
// Combinational instruction-lookup decoder: flags the known illegal encodings.
module inst_lookup_decoder
    import decode_issue_pkg::*;
(
    input  logic [INST_W-1:0] io_inst,
    output logic              io_sigs_valid
);

    // Every word is legal except the two reserved encodings.
    always_comb begin
        io_sigs_valid = !is_illegal(io_inst);
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue sequencer: circular instruction buffer in front of the lookup
// decoder, valid/ready issue, and trap capture of illegal head words.
// Optional feature: define DECODE_ISSUE_PERF_EN to add perf_issued/perf_illegal.
module decode_issue_ctrl
    import decode_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic              trap_valid,
    output logic [INST_W-1:0] trap_inst,
    input  logic              trap_ack,
    input  logic              flush,
    output logic              busy
`ifdef DECODE_ISSUE_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_issued,
    output logic [PERF_W-1:0] perf_illegal
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state_reg, state_next;
    logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [INST_W-1:0] trap_inst_reg, trap_inst_next;

    logic [INST_W-1:0] mem [DEPTH];

    logic [INST_W-1:0] head_inst;
    logic              head_legal;
    logic              not_empty;
    logic              push;
    logic              issue;
    logic              trap_take;
    logic              mem_we;

    assign head_inst = mem[rd_ptr_reg];
    assign not_empty = (count_reg != '0);

    inst_lookup_decoder u_decoder (
        .io_inst       (head_inst),
        .io_sigs_valid (head_legal)
    );

    // Handshake outputs depend only on registered state, never on in_valid/out_ready.
    always_comb begin
        in_ready   = (state_reg == RUN) && (count_reg < CW'(DEPTH));
        out_valid  = (state_reg == RUN) && not_empty && head_legal;
        out_inst   = not_empty ? head_inst : '0;
        trap_valid = (state_reg == TRAP);
        trap_inst  = trap_inst_reg;
        busy       = not_empty || (state_reg == TRAP);
    end

    assign push      = in_valid && in_ready;
    assign issue     = out_valid && out_ready;
    assign trap_take = (state_reg == RUN) && not_empty && !head_legal;
    assign mem_we    = push && !flush;

    // Next-state: flush wins over everything, then per-state buffer/trap handling.
    always_comb begin
        state_next     = state_reg;
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        trap_inst_next = trap_inst_reg;
        if (flush) begin
            state_next  = RUN;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    // An illegal head is popped into the trap register.
                    if (push) begin
                        wr_ptr_next = wr_ptr_reg + PW'(1);
                    end
                    if (issue || trap_take) begin
                        rd_ptr_next = rd_ptr_reg + PW'(1);
                    end
                    case ({push, (issue || trap_take)})
                        2'b10:   count_next = count_reg + CW'(1);
                        2'b01:   count_next = count_reg - CW'(1);
                        default: count_next = count_reg;
                    endcase
                    if (trap_take) begin
                        state_next     = TRAP;
                        trap_inst_next = head_inst;
                    end
                end
                TRAP: begin
                    // Acknowledge discards whatever was queued behind the bad word.
                    if (trap_ack) begin
                        state_next  = RUN;
                        rd_ptr_next = '0;
                        wr_ptr_next = '0;
                        count_next  = '0;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RUN;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            trap_inst_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            trap_inst_reg <= trap_inst_next;
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= in_inst;
        end
    end

`ifdef DECODE_ISSUE_PERF_EN
    logic [PERF_W-1:0] perf_issued_reg;
    logic [PERF_W-1:0] perf_illegal_reg;

    // Free-running wrap-around counters; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued_reg  <= '0;
            perf_illegal_reg <= '0;
        end else begin
            if (issue && !flush) begin
                perf_issued_reg <= perf_issued_reg + PERF_W'(1);
            end
            if (trap_take && !flush) begin
                perf_illegal_reg <= perf_illegal_reg + PERF_W'(1);
            end
        end
    end

    assign perf_issued  = perf_issued_reg;
    assign perf_illegal = perf_illegal_reg;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: inputs driven and outputs checked on the falling edge.
module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        trap_valid;
    logic [31:0] trap_inst;
    logic        trap_ack;
    logic        flush;
    logic        busy;
`ifdef DECODE_ISSUE_PERF_EN
    logic [15:0] perf_issued;
    logic [15:0] perf_illegal;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decode_issue_ctrl #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .trap_valid (trap_valid),
        .trap_inst  (trap_inst),
        .trap_ack   (trap_ack),
        .flush      (flush),
        .busy       (busy)
`ifdef DECODE_ISSUE_PERF_EN
        ,
        .perf_issued  (perf_issued),
        .perf_illegal (perf_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    initial begin
        int sent;
        int got;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        out_ready = 1'b0;
        trap_ack  = 1'b0;
        flush     = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_trap_valid", 32'(trap_valid), 32'd0);
        chk("rst_trap_inst", trap_inst, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef DECODE_ISSUE_PERF_EN
        chk("rst_perf_issued", 32'(perf_issued), 32'd0);
        chk("rst_perf_illegal", 32'(perf_illegal), 32'd0);
`endif
        reset_n = 1'b1;

        // Streaming with out_ready high
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h13;
        @(negedge clk);
        chk("stream_v0", 32'(out_valid), 32'd1);
        chk("stream_i0", out_inst, 32'h13);
        in_inst = 32'h33;
        @(negedge clk);
        chk("stream_v1", 32'(out_valid), 32'd1);
        chk("stream_i1", out_inst, 32'h33);
        in_inst = 32'h73;
        @(negedge clk);
        chk("stream_v2", 32'(out_valid), 32'd1);
        chk("stream_i2", out_inst, 32'h73);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_busy", 32'(busy), 32'd0);
        chk("stream_empty_inst", out_inst, 32'h0);
        $display("stream: 3 words issued");

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h1;
        @(negedge clk);
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        in_inst = 32'h2;
        @(negedge clk);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head", out_inst, 32'h1);
        in_inst = 32'h3;
        @(negedge clk);
        chk("bp_held_off", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_issue2_v", 32'(out_valid), 32'd1);
        chk("bp_issue2_i", out_inst, 32'h2);
        @(negedge clk);
        chk("bp_drained", 32'(busy), 32'd0);
        $display("backpressure: 2 words issued, third held off");

        // Flush suppresses a simultaneous push
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h5;
        @(negedge clk);
        flush = 1'b1; in_inst = 32'h6;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_push_busy", 32'(busy), 32'd0);
        $display("flush: buffer emptied, push suppressed");

        // Flush has priority over trap_ack
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h277b;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fp_ill_not_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("fp_trap_valid", 32'(trap_valid), 32'd1);
        chk("fp_trap_inst", trap_inst, 32'h277b);
        flush = 1'b1; trap_ack = 1'b1;
        @(negedge clk);
        flush = 1'b0; trap_ack = 1'b0;
        chk("fp_trap_clear", 32'(trap_valid), 32'd0);
        chk("fp_busy", 32'(busy), 32'd0);
        chk("fp_in_ready", 32'(in_ready), 32'd1);
`ifdef DECODE_ISSUE_PERF_EN
        chk("fp_perf_illegal", 32'(perf_illegal), 32'd1);
`endif
        $display("flush priority: trap 0x277b cleared");

        // Illegal word in the stream
        in_valid = 1'b1; in_inst = 32'h13;
        @(negedge clk);
        chk("ill_issue_v", 32'(out_valid), 32'd1);
        chk("ill_issue_i", out_inst, 32'h13);
        in_inst = 32'h257b;
        @(negedge clk);
        chk("ill_head_blocked", 32'(out_valid), 32'd0);
        chk("ill_no_trap_yet", 32'(trap_valid), 32'd0);
        in_inst = 32'h33;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ill_trap_valid", 32'(trap_valid), 32'd1);
        chk("ill_trap_inst", trap_inst, 32'h257b);
        chk("ill_out_valid", 32'(out_valid), 32'd0);
        chk("ill_in_ready", 32'(in_ready), 32'd0);
        chk("ill_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ill_hold_trap", 32'(trap_valid), 32'd1);
        chk("ill_hold_no_issue", 32'(out_valid), 32'd0);
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("ill_ack_clear", 32'(trap_valid), 32'd0);
        chk("ill_ack_empty", 32'(busy), 32'd0);
        chk("ill_ack_ready", 32'(in_ready), 32'd1);
`ifdef DECODE_ISSUE_PERF_EN
        chk("ill_perf_issued", 32'(perf_issued), 32'd6);
        chk("ill_perf_illegal", 32'(perf_illegal), 32'd2);
`endif
        $display("illegal: trap on 0x257b, 0x33 discarded");

        // Pointer wrap-around with toggling out_ready
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            out_ready = c[0];
            in_valid  = (sent < 5);
            in_inst   = 32'hA0 + 32'(sent);
            if (out_valid && out_ready) begin
                chk("wrap_order", out_inst, 32'hA0 + 32'(got));
                $display("wrap: issue 0x%08h", out_inst);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("wrap_count", 32'(got), 32'd5);
        chk("wrap_drained", 32'(busy), 32'd0);

        // Asynchronous reset with two words buffered
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h11;
        @(negedge clk);
        in_inst = 32'h22;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_buffered", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_out_inst", out_inst, 32'h0);
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mr_no_issue", 32'(out_valid), 32'd0);
        chk("mr_idle", 32'(busy), 32'd0);
`ifdef DECODE_ISSUE_PERF_EN
        chk("mr_perf_issued", 32'(perf_issued), 32'd0);
`endif
        $display("reset: buffered words dropped");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
